// File: rtl/slot_reel_controller_pkg.sv
// Shared definitions for the slot reel controller: state encodings,
// seven-segment code table and legal parameter ranges.
// Pure package; no logic, no latency, no flow control.
package slot_reel_controller_pkg;

  typedef enum logic [1:0] {
    G_IDLE   = 2'd0,
    G_RUN    = 2'd1,
    G_RESULT = 2'd2
  } glob_state_t;

  typedef enum logic [1:0] {
    R_HALT    = 2'd0,
    R_SPIN    = 2'd1,
    R_DECEL   = 2'd2,
    R_STOPPED = 2'd3
  } reel_state_t;

  localparam int N_REEL_MIN      = 1;
  localparam int N_REEL_MAX      = 8;
  localparam int REEL_MOD_MIN    = 1;
  localparam int REEL_MOD_MAX    = 10;
  localparam int STEP_BASE_MIN   = 2;
  localparam int DECEL_STEPS_MIN = 0;
  localparam int SCAN_DIV_MIN    = 1;

  // {a,b,c,d,e,f,g,dp}, MSB = a; entry 9 first, entry 0 last
  localparam logic [9:0][7:0] SEG_CODES = {
    8'b11110110,  // 9
    8'b11111110,  // 8
    8'b11100000,  // 7
    8'b10111110,  // 6
    8'b10110110,  // 5
    8'b01100110,  // 4
    8'b11110010,  // 3
    8'b11011010,  // 2
    8'b01100000,  // 1
    8'b11111100   // 0
  };

  function automatic logic [7:0] seg_encode(input logic [3:0] v);
    logic [7:0] code;
    code = 8'h00;
    if (v <= 4'd9) code = SEG_CODES[v];
    return code;
  endfunction

endpackage

// File: rtl/reel_unit.sv
// One reel: spins with period STEP_P, decelerates with doubling periods, then stops.
// Value and state are registered; a step lands exactly one period after the counter clears.
// No backpressure: launch/stop are single-cycle pulses qualified by the parent.
module reel_unit
  import slot_reel_controller_pkg::*;
#(
  parameter int REEL_MOD    = 10,
  parameter int STEP_P      = 2500000,
  parameter int DECEL_STEPS = 3,
  parameter int CNT_W       = 27
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_launch,
  input  logic        i_stop,
  input  logic        i_next_done,
  output reel_state_t o_state,
  output logic [3:0]  o_val
);

  localparam int         DW      = (DECEL_STEPS > 0) ? $clog2(DECEL_STEPS + 1) : 1;
  localparam logic [3:0] VAL_MAX = 4'(REEL_MOD - 1);

  reel_state_t      r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt, w_period;
  logic [DW-1:0]    r_dstep, w_dstep_nxt;
  logic [3:0]       r_val, w_val_nxt, w_val_inc;
  logic             w_last;

  // current step period: base while spinning, 2^(k+1) * base for deceleration step k
  always_comb begin
    if (r_state == R_DECEL) w_period = CNT_W'(STEP_P) << (r_dstep + 1'b1);
    else                    w_period = CNT_W'(STEP_P);
    w_last    = (r_cnt == w_period - 1'b1);
    w_val_inc = (r_val >= VAL_MAX) ? 4'd0 : r_val + 4'd1;
  end

  // next-state logic: launch wins, stop only when the next-higher reel is already braking
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_dstep_nxt = r_dstep;
    w_val_nxt   = r_val;
    if (i_launch) begin
      w_state_nxt = R_SPIN;
      w_cnt_nxt   = '0;
      w_dstep_nxt = '0;
    end else begin
      case (r_state)
        R_SPIN: begin
          if (i_stop && i_next_done) begin
            w_state_nxt = R_DECEL;
            w_cnt_nxt   = '0;
            w_dstep_nxt = '0;
          end else if (w_last) begin
            w_cnt_nxt = '0;
            w_val_nxt = w_val_inc;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        R_DECEL: begin
          if (int'(r_dstep) >= DECEL_STEPS) begin
            // no deceleration steps configured: stop the cycle after acceptance
            w_state_nxt = R_STOPPED;
          end else if (w_last) begin
            w_cnt_nxt   = '0;
            w_val_nxt   = w_val_inc;
            w_dstep_nxt = r_dstep + 1'b1;
            if (int'(r_dstep) == DECEL_STEPS - 1) w_state_nxt = R_STOPPED;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        default: ;  // HALT and STOPPED hold everything
      endcase
    end
  end

  // state, counter and value registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= R_HALT;
      r_cnt   <= '0;
      r_dstep <= '0;
      r_val   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_dstep <= w_dstep_nxt;
      r_val   <= w_val_nxt;
    end
  end

  assign o_state = r_state;
  assign o_val   = r_val;

endmodule

// File: rtl/slot_reel_controller.sv
// Slot machine controller: N_REEL reels, stop ordering from the top reel down, multiplexed display.
// Outputs registered; RESULT flags valid one edge after the last reel stops; display one edge behind reel_val.
// No backpressure: start/stop are single-cycle pulses; start in RUN and ineligible stops are dropped.
module slot_reel_controller
  import slot_reel_controller_pkg::*;
#(
  parameter int N_REEL      = 6,
  parameter int REEL_MOD    = 10,
  parameter int STEP_BASE   = 2500000,
  parameter int DECEL_STEPS = 3,
  parameter int SCAN_DIV    = 100000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [N_REEL-1:0]     stop_pulse,
  output logic [4*N_REEL-1:0]   reel_val,
  output logic [7:0]            digit_seg,
  output logic [7:0]            digit_cath,
  output logic                  all_stopped,
  output logic                  win
);

  // step counters hold the longest deceleration period of the slowest reel
  localparam int         STEP_MAX  = STEP_BASE * N_REEL * (2 ** DECEL_STEPS);
  localparam int         CNT_W     = $clog2(STEP_MAX + 1);
  localparam int         SW        = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [2:0] SLOT_LAST = 3'(N_REEL - 1);

  glob_state_t       r_gstate, w_gstate_nxt;
  logic              w_launch;
  logic [N_REEL-1:0] w_stop_en, w_next_done, w_is_stopped;
  reel_state_t       w_reel_state [N_REEL];
  logic              w_all_eq;
  logic              r_all_stopped, r_win;

  logic [SW-1:0]     r_scan_cnt;
  logic [2:0]        r_slot, w_slot_nxt;
  logic              r_scan_act, w_scan_act_nxt, w_scan_tick;
  logic [7:0]        r_seg, r_cath;
  logic [3:0]        w_slot_val;

  assign w_stop_en = stop_pulse & {N_REEL{r_gstate == G_RUN}};

  for (genvar i = 0; i < N_REEL; i++) begin : g_reel
    if (i == N_REEL - 1) begin : g_top
      assign w_next_done[i] = 1'b1;
    end else begin : g_lower
      assign w_next_done[i] = (w_reel_state[i+1] == R_DECEL) ||
                              (w_reel_state[i+1] == R_STOPPED);
    end
    assign w_is_stopped[i] = (w_reel_state[i] == R_STOPPED);

    reel_unit #(
      .REEL_MOD    (REEL_MOD),
      .STEP_P      (STEP_BASE * (i + 1)),
      .DECEL_STEPS (DECEL_STEPS),
      .CNT_W       (CNT_W)
    ) u_reel (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_launch    (w_launch),
      .i_stop      (w_stop_en[i]),
      .i_next_done (w_next_done[i]),
      .o_state     (w_reel_state[i]),
      .o_val       (reel_val[4*i +: 4])
    );
  end

  // global FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_gstate <= G_IDLE;
    else        r_gstate <= w_gstate_nxt;
  end

  // global next state: start launches from IDLE/RESULT only; RESULT once every reel is stopped
  always_comb begin
    w_gstate_nxt = r_gstate;
    w_launch     = 1'b0;
    case (r_gstate)
      G_IDLE, G_RESULT: begin
        if (start) begin
          w_launch     = 1'b1;
          w_gstate_nxt = G_RUN;
        end
      end
      G_RUN: begin
        if (&w_is_stopped) w_gstate_nxt = G_RESULT;
      end
      default: w_gstate_nxt = G_IDLE;
    endcase
  end

  // all reel values equal to reel 0
  always_comb begin
    w_all_eq = 1'b1;
    for (int i = 1; i < N_REEL; i++) begin
      if (reel_val[4*i +: 4] != reel_val[3:0]) w_all_eq = 1'b0;
    end
  end

  // result flags track the state being entered; values are frozen throughout RESULT
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_all_stopped <= 1'b0;
      r_win         <= 1'b0;
    end else begin
      r_all_stopped <= (w_gstate_nxt == G_RESULT);
      r_win         <= (w_gstate_nxt == G_RESULT) && w_all_eq;
    end
  end

  // scan slot sequencing: blank until the first slot, then 0..N_REEL-1 repeating
  always_comb begin
    w_scan_tick    = (r_scan_cnt == SW'(SCAN_DIV - 1));
    w_scan_act_nxt = r_scan_act | w_scan_tick;
    w_slot_nxt     = r_slot;
    if (w_scan_tick) begin
      if (!r_scan_act || r_slot == SLOT_LAST) w_slot_nxt = 3'd0;
      else                                    w_slot_nxt = r_slot + 3'd1;
    end
    w_slot_val = reel_val[{w_slot_nxt, 2'b00} +: 4];
  end

  // scan registers; cathode and segments always written together
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_scan_cnt <= '0;
      r_slot     <= 3'd0;
      r_scan_act <= 1'b0;
      r_cath     <= 8'hFF;
      r_seg      <= 8'h00;
    end else begin
      r_scan_cnt <= w_scan_tick ? '0 : r_scan_cnt + 1'b1;
      r_slot     <= w_slot_nxt;
      r_scan_act <= w_scan_act_nxt;
      r_cath     <= w_scan_act_nxt ? ~(8'h01 << w_slot_nxt) : 8'hFF;
      r_seg      <= w_scan_act_nxt ? seg_encode(w_slot_val) : 8'h00;
    end
  end

  assign all_stopped = r_all_stopped;
  assign win         = r_win;
  assign digit_cath  = r_cath;
  assign digit_seg   = r_seg;

endmodule

// File: tb/tb_slot_reel_controller.sv
// Directed bench: idle scan, spin timeline with stop ordering, RESULT display,
// async reset mid-deceleration, and a REEL_MOD=1 win scenario on a second instance.
module tb_slot_reel_controller;

  logic        clk = 1'b0;
  logic        rst_n, rst1_n, start, start1;
  logic [2:0]  stop, stop1;
  logic [11:0] val, val1;
  logic [7:0]  seg, cath, seg1, cath1;
  logic        all_s, win_s, all1, win1;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int t0, t1, rise;

  typedef struct {
    int          edge_n;
    logic        st;
    logic [2:0]  sp;
    logic [11:0] v;
    logic        a;
    logic        w;
  } vec_t;
  vec_t tbl[$];

  always #5 clk = ~clk;

  slot_reel_controller #(
    .N_REEL(3), .REEL_MOD(10), .STEP_BASE(4), .DECEL_STEPS(2), .SCAN_DIV(2)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop_pulse(stop),
    .reel_val(val), .digit_seg(seg), .digit_cath(cath),
    .all_stopped(all_s), .win(win_s)
  );

  slot_reel_controller #(
    .N_REEL(3), .REEL_MOD(1), .STEP_BASE(4), .DECEL_STEPS(2), .SCAN_DIV(2)
  ) u_dut1 (
    .clk(clk), .rst_n(rst1_n), .start(start1), .stop_pulse(stop1),
    .reel_val(val1), .digit_seg(seg1), .digit_cath(cath1),
    .all_stopped(all1), .win(win1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic add(input int e, input logic s, input logic [2:0] sp,
                     input logic [11:0] v, input logic a, input logic w);
    vec_t r;
    r.edge_n = e; r.st = s; r.sp = sp; r.v = v; r.a = a; r.w = w;
    tbl.push_back(r);
  endtask

  function automatic logic [7:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0: return 8'b11111100;
      4'd1: return 8'b01100000;
      4'd2: return 8'b11011010;
      4'd3: return 8'b11110010;
      4'd4: return 8'b01100110;
      4'd5: return 8'b10110110;
      4'd6: return 8'b10111110;
      4'd7: return 8'b11100000;
      4'd8: return 8'b11111110;
      4'd9: return 8'b11110110;
      default: return 8'h00;
    endcase
  endfunction

  // walk one full scan round and check each slot shows its reel's digit
  task automatic check_segs(input logic [11:0] v);
    int s;
    repeat (6) begin
      tick();
      s = -1;
      if (cath == 8'hFE) s = 0;
      if (cath == 8'hFD) s = 1;
      if (cath == 8'hFB) s = 2;
      if (s < 0) check("result_cath_onehot", {24'h0, cath}, 32'h0000_00FE);
      else       check($sformatf("result_seg_slot%0d", s), {24'h0, seg}, {24'h0, seg_of(v[4*s +: 4])});
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] exp_cath, exp_seg;

    // edge (cycles after start), start, stop mask, {reel2,reel1,reel0}, all_stopped, win
    add(  0, 1, 3'b000, 12'h000, 0, 0);
    add(  3, 0, 3'b000, 12'h000, 0, 0);
    add(  4, 0, 3'b000, 12'h001, 0, 0);
    add(  7, 0, 3'b000, 12'h001, 0, 0);
    add(  8, 0, 3'b000, 12'h012, 0, 0);
    add( 11, 0, 3'b000, 12'h012, 0, 0);
    add( 12, 0, 3'b000, 12'h113, 0, 0);
    add( 36, 0, 3'b000, 12'h349, 0, 0);
    add( 39, 0, 3'b000, 12'h349, 0, 0);
    add( 40, 0, 3'b000, 12'h350, 0, 0);  // reel0 wraps 9 -> 0
    add( 41, 0, 3'b001, 12'h350, 0, 0);  // reel0 stop while reel1 spins: ignored
    add( 44, 0, 3'b000, 12'h351, 0, 0);
    add( 45, 0, 3'b010, 12'h351, 0, 0);  // reel1 stop while reel2 spins: ignored
    add( 48, 0, 3'b000, 12'h462, 0, 0);
    add( 50, 0, 3'b100, 12'h462, 0, 0);  // reel2 accepted
    add( 52, 0, 3'b011, 12'h463, 0, 0);  // only reel1 accepted
    add( 54, 0, 3'b001, 12'h463, 0, 0);  // reel0 accepted
    add( 56, 1, 3'b000, 12'h463, 0, 0);  // start in RUN ignored
    add( 61, 0, 3'b000, 12'h463, 0, 0);
    add( 62, 0, 3'b000, 12'h464, 0, 0);  // reel0 decel step 1
    add( 68, 0, 3'b000, 12'h474, 0, 0);  // reel1 decel step 1
    add( 74, 0, 3'b000, 12'h574, 0, 0);  // reel2 decel step 1 (t+24)
    add( 78, 0, 3'b000, 12'h575, 0, 0);  // reel0 decel step 2, stopped
    add(100, 0, 3'b000, 12'h585, 0, 0);  // reel1 decel step 2, stopped
    add(122, 0, 3'b000, 12'h685, 0, 0);  // reel2 decel step 2 (t+72), stopped
    add(123, 0, 3'b000, 12'h685, 1, 0);  // RESULT, no win
    add(130, 1, 3'b000, 12'h685, 0, 0);  // restart from RESULT keeps values
    add(134, 0, 3'b000, 12'h686, 0, 0);

    rst_n = 1'b0; rst1_n = 1'b0;
    start = 1'b0; start1 = 1'b0;
    stop  = 3'b000; stop1 = 3'b000;
    repeat (3) tick();

    check("rst_val",  {20'h0, val},  32'h0);
    check("rst_cath", {24'h0, cath}, 32'h0000_00FF);
    check("rst_seg",  {24'h0, seg},  32'h0);
    check("rst_all",  {31'h0, all_s}, 32'h0);
    check("rst_win",  {31'h0, win_s}, 32'h0);

    // idle scan after reset release
    rst_n = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (k < 2) begin
        exp_cath = 8'hFF;
        exp_seg  = 8'h00;
      end else begin
        exp_cath = ~(8'h01 << (((k - 2) / 2) % 3));
        exp_seg  = 8'b11111100;
      end
      check($sformatf("idle_cath_%0d", k), {24'h0, cath}, {24'h0, exp_cath});
      check($sformatf("idle_seg_%0d", k),  {24'h0, seg},  {24'h0, exp_seg});
    end

    // main timeline
    t0 = cyc + 1;
    foreach (tbl[j]) begin
      while (cyc < t0 + tbl[j].edge_n - 1) tick();
      start = tbl[j].st;
      stop  = tbl[j].sp;
      tick();
      start = 1'b0;
      stop  = 3'b000;
      check($sformatf("val_e%0d", tbl[j].edge_n), {20'h0, val},   {20'h0, tbl[j].v});
      check($sformatf("all_e%0d", tbl[j].edge_n), {31'h0, all_s}, {31'h0, tbl[j].a});
      check($sformatf("win_e%0d", tbl[j].edge_n), {31'h0, win_s}, {31'h0, tbl[j].w});
      if (tbl[j].a) check_segs(tbl[j].v);
    end

    // async reset while reel2 is decelerating
    stop = 3'b100;
    tick();
    stop = 3'b000;
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    check("arst_val",  {20'h0, val},   32'h0);
    check("arst_all",  {31'h0, all_s}, 32'h0);
    check("arst_cath", {24'h0, cath},  32'h0000_00FF);
    check("arst_seg",  {24'h0, seg},   32'h0);

    // REEL_MOD = 1: every reel reads 0, so stopping all of them is a win
    rst1_n = 1'b1;
    repeat (2) tick();
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    t1 = cyc;
    while (cyc < t1 + 1) tick();
    stop1 = 3'b100; tick(); stop1 = 3'b000;
    while (cyc < t1 + 3) tick();
    stop1 = 3'b010; tick(); stop1 = 3'b000;
    while (cyc < t1 + 5) tick();
    stop1 = 3'b001; tick(); stop1 = 3'b000;
    rise = -1;
    for (int k = 0; k < 200; k++) begin
      tick();
      if (all1) begin
        rise = cyc - t1;
        break;
      end
    end
    check("mod1_result_edge", rise, 32'd75);
    check("mod1_win", {31'h0, win1}, 32'h1);
    check("mod1_val", {20'h0, val1}, 32'h0);
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    check("mod1_restart_win", {31'h0, win1}, 32'h0);
    check("mod1_restart_all", {31'h0, all1}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
